disp_arbiter: RTL and testbench
===============================

// Module: disp_arbiter
// PURPOSE
//  Shares the single 4-digit seven-segment display between N_CLIENTS producers (e.g. debounced
//  and raw event counters). Clients post 16-bit values with one-cycle update strobes. Each
//  grant holds the display for a minimum dwell, then passes round-robin to the next client with a
//  pending update. Output digits drive disp_mux in0..in3 directly.
// PARAMETERS
//  N_CLIENTS    4           number of clients; 2..8
//  HOLD_CYCLES  50_000_000  minimum cycles a grant stays on the display; >=1
//  OW           $clog2(N_CLIENTS)  owner index width (derived, localparam)
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  reset      in   1        asynchronous, active-high reset
//  upd        in   N        per-client update strobe, one cycle per new value
//  data       in   16*N     client i value at data[16*i +: 16], sampled only when captured
//  lock       in   1        level; freezes current owner (dwell counter pauses)
//  next       in   1        one-cycle pulse (debounced button tick); forces advance, overrides lock
//  d0..d3     out  4 each   displayed nibbles, d0 = value[3:0] .. d3 = value[15:12]
//  owner      out  OW       index of client on display
//  owner_vld  out  1        high once any grant has occurred since reset
//  grant      out  1        one-cycle pulse, coincident with first cycle of a new owner's value
//  pending    out  N        registered pending-update flags
// BEHAVIOUR
//  Reset: state IDLE, pending=0, owner=0, owner_vld=0, d0..d3=0, grant=0, dwell counter=0.
//  pending[i] set on upd[i] (next edge), cleared on the edge that grants i.
//  Pick: round-robin over pending, search starts at owner+1 mod N (from 0 when !owner_vld).
//  States:
//   IDLE  - no owner. Any pending bit -> grant pick, go HOLD.
//   HOLD  - counter loaded HOLD_CYCLES-1 at grant, decrements each cycle unless lock.
//           At 0: go DWELL (HOLD_CYCLES=1 -> exactly one HOLD cycle).
//   DWELL - owner kept indefinitely. If !lock and any pending -> grant pick, go HOLD.
//  Grant edge: owner<=pick, snapshot data[pick] into display register, owner_vld<=1, grant<=1.
//  Latency: upd[i] at edge t -> pending at t+1 -> in IDLE/DWELL, new digits and grant after t+2.
//  Owner updates: upd[owner] in HOLD/DWELL refreshes the snapshot at the next edge.
//   No pending bit, no grant pulse, counter unaffected.
//  next: if any non-owner pending -> grant pick immediately from any state, counter reloads.
//   Else, if owner_vld -> grant (owner+1) mod N with its current data (forced rotate).
//   Else, in IDLE with nothing pending -> grant client 0.
//   next in same cycle as counter expiry or DWELL grant -> exactly one grant.
//  Simultaneous: upd[i] on the edge i is granted -> pending[i] ends 0; snapshot takes that
//   cycle's data[i].
//  lock deasserted in DWELL with pending -> grant on the next edge.
//  Reset mid-HOLD -> all state to reset values asynchronously; nothing retained.
//  Counter width = $clog2(HOLD_CYCLES); no wrap, saturates at 0.
// STRUCTURE
//  Package disp_arb_pkg:
//   - state enum {IDLE, HOLD, DWELL}
//   - localparams DIG_W=4, N_DIG=4, VAL_W=16
//  Sub-module rr_pick (combinational round-robin picker):
//   - inputs req[N], base[OW]
//   - outputs gnt_idx[OW], any
//  Top holds FSM, dwell counter, pending regs, snapshot and output registers.
// TESTING (N_CLIENTS=4, HOLD_CYCLES=8)
//  1 reset
//    stimulus: reset mid-run
//    response: d0..d3=0, owner_vld=0, grant=0, pending=0 while reset high and 1 cycle after
//  2 first grant from IDLE
//    stimulus: upd[2] with data2=16'h1234
//    response: 2 edges later grant=1, owner=2, {d3,d2,d1,d0}=1,2,3,4
//  3 round-robin after dwell
//    stimulus: owner=1; upd[0] and upd[3] together
//    response: 8 cycles after grant, owner=3; next grant 8 cycles later -> owner=0
//  4 owner refresh
//    stimulus: owner=2 in HOLD; upd[2] with 16'hBEEF
//    response: digits BEEF next edge; no grant pulse; pending[2]=0; dwell end unchanged
//  5 lock
//    stimulus: lock high during HOLD for 5 cycles
//    response: expiry delayed by 5 cycles
//    stimulus: lock in DWELL with pending[1]
//    response: no grant until lock falls; then grant owner=1 next edge
//  6 next
//    stimulus: next pulse at HOLD count 5 with pending[0]
//    response: immediate grant to 0
//    stimulus: next with nothing pending, owner=3
//    response: owner=0 showing data0
//    stimulus: next coincident with expiry
//    response: single grant pulse

Source files
------------

// File: rtl/disp_arb_pkg.sv
// Shared types and widths for the display arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package disp_arb_pkg;

    // IDLE: nobody has been granted yet since reset.
    // HOLD: the minimum dwell is still running for the current owner.
    // DWELL: the dwell is satisfied, and the owner stays on until a pending client takes over.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DWELL = 2'd2
    } state_t;

    localparam int DIG_W = 4;
    localparam int N_DIG = 4;
    localparam int VAL_W = DIG_W * N_DIG;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: this block returns the first set request at or after base, wrapping modulo N.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; any=0 means gnt_idx is don't-care (driven 0).
// Ports: req[N] request vector, base[OW] search start, gnt_idx[OW] winner, any = some request set.
module rr_pick #(
    parameter int N  = 4,
    parameter int OW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] base,
    output logic [OW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        // This loop walks the rotation from farthest to nearest. The last hit is the closest one to base.
        for (int k = N - 1; k >= 0; k--) begin
            int unsigned w_idx;
            w_idx = (int'(base) + k) % N;
            if (req[w_idx]) begin
                gnt_idx = OW'(w_idx);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner of the single 4-digit display among N_CLIENTS value producers, with a minimum dwell per grant.
// Latency: upd -> pending flag 1 edge; pending -> grant/new digits 1 more edge when the display is free.
// Backpressure: none; updates are never dropped, they stay pending until granted. lock pauses rotation, and next forces a rotation.
// Ports: clk, reset (async, active-high); upd[N] strobes; data[16N] values; lock level; next pulse;
//        d0..d3 displayed nibbles; owner / owner_vld; grant pulse; pending[N] flags.
module disp_arbiter
    import disp_arb_pkg::*;
#(
    parameter  int N_CLIENTS   = 4,
    parameter  int HOLD_CYCLES = 50_000_000,
    localparam int OW          = $clog2(N_CLIENTS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CLIENTS-1:0]       upd,
    input  logic [VAL_W*N_CLIENTS-1:0] data,
    input  logic                       lock,
    input  logic                       next,
    output logic [DIG_W-1:0]           d0,
    output logic [DIG_W-1:0]           d1,
    output logic [DIG_W-1:0]           d2,
    output logic [DIG_W-1:0]           d3,
    output logic [OW-1:0]              owner,
    output logic                       owner_vld,
    output logic                       grant,
    output logic [N_CLIENTS-1:0]       pending
);

    // HOLD_CYCLES=1 would give a zero-width counter, so the counter keeps at least one bit.
    localparam int            CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [N_CLIENTS-1:0]   r_pending;
    logic [OW-1:0]          r_owner;
    logic                   r_owner_vld;
    logic                   r_grant;
    logic [VAL_W-1:0]       r_snap;

    state_t                 w_state_nxt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [OW-1:0]          w_base;
    logic [OW-1:0]          w_pick_idx;
    logic                   w_pick_any;
    logic                   w_grant_do;
    logic [OW-1:0]          w_grant_idx;
    logic [N_CLIENTS-1:0]   w_grant_oh;
    logic [N_CLIENTS-1:0]   w_owner_mask;
    logic [N_CLIENTS-1:0]   w_pend_nxt;
    logic                   w_refresh;
    logic [OW-1:0]          w_sel_idx;
    logic [VAL_W-1:0]       w_data_sel;

    // The search starts just after the current owner. Before the first grant, it starts at client 0.
    // w_base is also the forced-rotate target when next fires and nothing is pending.
    always_comb begin
        w_base = '0;
        if (r_owner_vld && (r_owner != OW'(N_CLIENTS - 1))) begin
            w_base = r_owner + OW'(1);
        end
    end

    rr_pick #(
        .N  (N_CLIENTS),
        .OW (OW)
    ) u_rr_pick (
        .req     (r_pending),
        .base    (w_base),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_do  = 1'b0;
        w_grant_idx = w_pick_idx;

        if (next) begin
            // next overrides lock and the dwell in every state.
            // Exactly one grant is issued even when expiry coincides.
            w_grant_do = 1'b1;
            if (!w_pick_any) begin
                w_grant_idx = w_base;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_grant_do = w_pick_any;
                end
                HOLD: begin
                    if (!lock) begin
                        if (r_cnt == '0) begin
                            // The dwell is complete on this edge. Hand over directly if anyone is waiting.
                            if (w_pick_any) begin
                                w_grant_do = 1'b1;
                            end else begin
                                w_state_nxt = DWELL;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt - CW'(1);
                        end
                    end
                end
                DWELL: begin
                    w_grant_do = w_pick_any && !lock;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        if (w_grant_do) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = CNT_LOAD;
        end
    end

    assign w_grant_oh = {{(N_CLIENTS-1){1'b0}}, w_grant_do} << w_grant_idx;

    // An update from the owner that is not being displaced refreshes the digits in place.
    // It never becomes pending. An update from the old owner on a handover edge does become pending.
    assign w_owner_mask = {{(N_CLIENTS-1){1'b0}}, (r_owner_vld && !w_grant_do)} << r_owner;
    assign w_refresh    = r_owner_vld && !w_grant_do && upd[r_owner];
    assign w_pend_nxt   = (r_pending | (upd & ~w_owner_mask)) & ~w_grant_oh;

    assign w_sel_idx  = w_grant_do ? w_grant_idx : r_owner;
    assign w_data_sel = data[VAL_W*w_sel_idx +: VAL_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pending   <= '0;
            r_owner     <= '0;
            r_owner_vld <= 1'b0;
            r_grant     <= 1'b0;
            r_snap      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pend_nxt;
            r_grant   <= w_grant_do;
            if (w_grant_do) begin
                r_owner     <= w_grant_idx;
                r_owner_vld <= 1'b1;
                r_snap      <= w_data_sel;
            end else if (w_refresh) begin
                r_snap <= w_data_sel;
            end
        end
    end

    assign d0        = r_snap[DIG_W*0 +: DIG_W];
    assign d1        = r_snap[DIG_W*1 +: DIG_W];
    assign d2        = r_snap[DIG_W*2 +: DIG_W];
    assign d3        = r_snap[DIG_W*3 +: DIG_W];
    assign owner     = r_owner;
    assign owner_vld = r_owner_vld;
    assign grant     = r_grant;
    assign pending   = r_pending;

endmodule

// File: tb/tb_disp_arbiter.sv
module tb_disp_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int OW   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    upd;
    logic [16*N-1:0] data;
    logic            lock;
    logic            next;
    logic [3:0]      d0, d1, d2, d3;
    logic [OW-1:0]   owner;
    logic            owner_vld;
    logic            grant;
    logic [N-1:0]    pending;

    always #5 clk = ~clk;

    disp_arbiter #(
        .N_CLIENTS   (N),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .upd       (upd),
        .data      (data),
        .lock      (lock),
        .next      (next),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .owner     (owner),
        .owner_vld (owner_vld),
        .grant     (grant),
        .pending   (pending)
    );

    typedef struct packed {
        logic          grant;
        logic [OW-1:0] owner;
        logic          vld;
        logic [15:0]   val;
        logic [N-1:0]  pend;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: served = unlocked edges since the last grant (saturating at HOLD).
    bit [N-1:0]  m_pend;
    int          m_own;
    bit          m_vld;
    int          m_served;
    logic [15:0] m_val;
    bit          m_grant;
    logic [15:0] m_data [N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_first(input int base);
        for (int k = 0; k < N; k++) begin
            if (m_pend[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_pend   = '0;
        m_own    = 0;
        m_vld    = 1'b0;
        m_served = 0;
        m_val    = '0;
        m_grant  = 1'b0;
    endfunction

    function automatic void model_edge(input bit [N-1:0] u, input bit lk, input bit nx);
        int  base;
        int  g;
        bit  do_g;
        base = m_vld ? (m_own + 1) % N : 0;
        g    = rr_first(base);
        do_g = 1'b0;
        if (nx) begin
            do_g = 1'b1;
            if (g < 0) g = base;
        end else if (!m_vld) begin
            do_g = (g >= 0);
        end else if (!lk && (m_served >= HOLD - 1) && (g >= 0)) begin
            do_g = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (u[i] && !(m_vld && !do_g && i == m_own)) m_pend[i] = 1'b1;
        end
        if (do_g) begin
            m_pend[g] = 1'b0;
            m_val     = m_data[g];
            m_own     = g;
            m_vld     = 1'b1;
            m_served  = 0;
            m_grant   = 1'b1;
        end else begin
            m_grant = 1'b0;
            if (m_vld && u[m_own]) m_val = m_data[m_own];
            if (m_vld && !lk && m_served < HOLD) m_served++;
        end
    endfunction

    // Drive one cycle's inputs (mid-cycle), advance the model and queue the post-edge expectation.
    task automatic step(input bit [N-1:0] u, input bit lk, input bit nx, input bit rs);
        exp_t e;
        upd  = u;
        lock = lk;
        next = nx;
        for (int i = 0; i < N; i++) data[16*i +: 16] = m_data[i];
        reset = rs;
        if (rs) begin
            model_reset();
            #1;
            chk("async_rst_vld", {31'd0, owner_vld}, 32'd0);
            chk("async_rst_digits", {16'd0, d3, d2, d1, d0}, 32'd0);
        end else begin
            model_edge(u, lk, nx);
        end
        e.grant = m_grant;
        e.owner = OW'(m_own);
        e.vld   = m_vld;
        e.val   = m_val;
        e.pend  = m_pend;
        sb_q.push_back(e);
        @(posedge clk);
        #4;
    endtask

    task automatic run_quiet(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_owner(input int o);
        int k = 0;
        while (!(m_grant && m_own == o) && k < 40) begin
            step('0, 1'b0, 1'b0, 1'b0);
            k++;
        end
        if (!(m_grant && m_own == o)) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_owner: no grant to client %0d within 40 cycles", o);
        end
    endtask

    // Monitor: compares DUT outputs after every edge against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("grant", {31'd0, grant}, {31'd0, e.grant});
                chk("owner", {30'd0, owner}, {30'd0, e.owner});
                chk("owner_vld", {31'd0, owner_vld}, {31'd0, e.vld});
                chk("digits", {16'd0, d3, d2, d1, d0}, {16'd0, e.val});
                chk("pending", {28'd0, pending}, {28'd0, e.pend});
            end
        end
    end

    initial begin
        bit lk_r;
        reset = 1'b1;
        upd   = '0;
        lock  = 1'b0;
        next  = 1'b0;
        data  = '0;
        for (int i = 0; i < N; i++) m_data[i] = 16'h1111 * (i + 1);
        model_reset();
        @(posedge clk);
        #4;

        // Reset held, then released with quiet inputs.
        repeat (3) step('0, 1'b0, 1'b0, 1'b1);
        run_quiet(2);

        // First grant out of IDLE.
        m_data[2] = 16'h1234;
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        run_quiet(3);
        run_quiet(10);

        // Round robin: owner 1, then 0 and 3 post together.
        step(4'b0010, 1'b0, 1'b0, 1'b0);
        wait_owner(1);
        m_data[0] = 16'hA0A0;
        m_data[3] = 16'h3C3C;
        step(4'b1001, 1'b0, 1'b0, 1'b0);
        run_quiet(25);

        // Owner refresh during HOLD.
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        wait_owner(2);
        run_quiet(2);
        m_data[2] = 16'hBEEF;
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        run_quiet(12);

        // Lock during HOLD, then lock in DWELL with pending[1].
        step(4'b0001, 1'b0, 1'b0, 1'b0);
        wait_owner(0);
        repeat (5) step('0, 1'b1, 1'b0, 1'b0);
        run_quiet(12);
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (6) step('0, 1'b1, 1'b0, 1'b0);
        run_quiet(10);

        // next with pending[0] mid-HOLD.
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        wait_owner(2);
        run_quiet(1);
        step(4'b0001, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1, 1'b0);
        run_quiet(12);

        // next with nothing pending while owner=3: forced rotate to 0.
        step(4'b1000, 1'b0, 1'b0, 1'b0);
        wait_owner(3);
        run_quiet(12);
        m_data[0] = 16'h0F0F;
        step('0, 1'b0, 1'b1, 1'b0);
        run_quiet(3);

        // next coincident with dwell expiry while client 2 waits.
        step(4'b0010, 1'b0, 1'b0, 1'b0);
        wait_owner(1);
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20 && m_served < HOLD - 1; k++) step('0, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1, 1'b0);
        run_quiet(5);

        // Reset mid-HOLD.
        step(4'b1000, 1'b0, 1'b0, 1'b0);
        run_quiet(4);
        repeat (2) step('0, 1'b0, 1'b0, 1'b1);
        run_quiet(2);

        // Randomized traffic.
        lk_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bit [N-1:0] u;
            u = '0;
            if ($urandom_range(0, 5) == 0) u = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if (u[i] || $urandom_range(0, 9) == 0) m_data[i] = 16'($urandom);
            end
            if ($urandom_range(0, 19) == 0) lk_r = ~lk_r;
            if ($urandom_range(0, 800) == 0) begin
                step(u, lk_r, 1'b0, 1'b1);
                step('0, 1'b0, 1'b0, 1'b1);
            end else begin
                step(u, lk_r, ($urandom_range(0, 40) == 0), 1'b0);
            end
        end
        run_quiet(3);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
